// File: rtl/video_crtc_gen.sv
// video_crtc_gen -- 6845-style CRTC timing core.
//
// Produces horizontal/vertical sync, display enable, refresh address (MA) and
// raster address (RA) from CRTC register values. It also provides a hardware
// cursor with blink modes and a frame counter. Vertical and address geometry
// are captured at each frame boundary, so the register block can rewrite them
// at any time without tearing the current frame.
//
// Ports:
//   wb_clock_i / reset_n_i      system clock, async active-low reset
//   clk_en_i                    character-clock enable (all state gated by it)
//   h_total_i .. h_sync_pos_i   live horizontal geometry (R0..R2)
//   h_sync_width_i              R3[3:0], 0 encodes 16
//   v_sync_width_i              R3[7:4], 0 encodes 16
//   v_total_i, v_adjust_i,
//   v_displayed_i,
//   max_scan_line_i             vertical geometry, used from the next frame
//   v_sync_pos_i                live VSYNC row
//   cursor_*                    cursor mode, raster range and address
//   start_addr_i                frame start address, used from the next frame
//   h_sync_o, v_sync_o, de_o    timing outputs
//   cursor_o                    cursor hit at the current MA/RA
//   frame_start_o, frame_count_o  frame marker and 5-bit frame counter
//   ma_o, ra_o                  refresh and raster address
module video_crtc_gen #(
  parameter int H_WIDTH  = 8,
  parameter int V_WIDTH  = 7,
  parameter int RA_WIDTH = 5,
  parameter int MA_WIDTH = 14
) (
  input  logic                wb_clock_i,
  input  logic                reset_n_i,
  input  logic                clk_en_i,
  input  logic [H_WIDTH-1:0]  h_total_i,
  input  logic [H_WIDTH-1:0]  h_displayed_i,
  input  logic [H_WIDTH-1:0]  h_sync_pos_i,
  input  logic [3:0]          h_sync_width_i,
  input  logic [3:0]          v_sync_width_i,
  input  logic [V_WIDTH-1:0]  v_total_i,
  input  logic [RA_WIDTH-1:0] v_adjust_i,
  input  logic [V_WIDTH-1:0]  v_displayed_i,
  input  logic [V_WIDTH-1:0]  v_sync_pos_i,
  input  logic [RA_WIDTH-1:0] max_scan_line_i,
  input  logic [1:0]          cursor_mode_i,
  input  logic [RA_WIDTH-1:0] cursor_start_i,
  input  logic [RA_WIDTH-1:0] cursor_end_i,
  input  logic [MA_WIDTH-1:0] start_addr_i,
  input  logic [MA_WIDTH-1:0] cursor_addr_i,
  output logic                h_sync_o,
  output logic                v_sync_o,
  output logic                de_o,
  output logic                cursor_o,
  output logic                frame_start_o,
  output logic [4:0]          frame_count_o,
  output logic [MA_WIDTH-1:0] ma_o,
  output logic [RA_WIDTH-1:0] ra_o
);

  typedef enum logic {
    ST_ACTIVE = 1'b0,
    ST_ADJUST = 1'b1
  } state_e;

  localparam logic [H_WIDTH-1:0]  H_ONE  = 1;
  localparam logic [V_WIDTH-1:0]  V_ONE  = 1;
  localparam logic [RA_WIDTH-1:0] RA_ONE = 1;

  state_e                state_q, state_d;
  logic                  load_pending_q, load_pending_d;
  logic [H_WIDTH-1:0]    hc_q, hc_d;
  logic [RA_WIDTH-1:0]   ra_q, ra_d;
  logic [V_WIDTH-1:0]    vc_q, vc_d;
  logic [MA_WIDTH-1:0]   row_addr_q, row_addr_d;
  logic [4:0]            hs_cnt_q, hs_cnt_d;
  logic [4:0]            vs_cnt_q, vs_cnt_d;
  logic                  vs_done_q, vs_done_d;
  logic                  frame_start_q, frame_start_d;
  logic [4:0]            frame_count_q, frame_count_d;
  logic [V_WIDTH-1:0]    v_total_sh_q, v_total_sh_d;
  logic [V_WIDTH-1:0]    v_disp_sh_q, v_disp_sh_d;
  logic [RA_WIDTH-1:0]   v_adj_sh_q, v_adj_sh_d;
  logic [RA_WIDTH-1:0]   max_scan_sh_q, max_scan_sh_d;

  logic       line_end, row_end, frame_end, new_frame, row_enter;
  logic [4:0] hs_len, vs_len;
  logic       de_h, de_v, blink_on;

  always_comb begin
    line_end  = (hc_q == h_total_i);
    row_end   = line_end && (ra_q == max_scan_sh_q);
    // Frame ends either on the last raster of the last row (no adjust) or on
    // the last adjust line.
    frame_end = (state_q == ST_ACTIVE && row_end && vc_q == v_total_sh_q &&
                 v_adj_sh_q == '0) ||
                (state_q == ST_ADJUST && line_end && ra_q == v_adj_sh_q - RA_ONE);
    new_frame = load_pending_q || frame_end;
    hs_len    = (h_sync_width_i == 4'd0) ? 5'd16 : {1'b0, h_sync_width_i};
    vs_len    = (v_sync_width_i == 4'd0) ? 5'd16 : {1'b0, v_sync_width_i};
  end

  always_comb begin
    state_d        = state_q;
    load_pending_d = load_pending_q;
    hc_d           = hc_q;
    ra_d           = ra_q;
    vc_d           = vc_q;
    row_addr_d     = row_addr_q;
    hs_cnt_d       = hs_cnt_q;
    vs_cnt_d       = vs_cnt_q;
    vs_done_d      = vs_done_q;
    frame_start_d  = frame_start_q;
    frame_count_d  = frame_count_q;
    v_total_sh_d   = v_total_sh_q;
    v_disp_sh_d    = v_disp_sh_q;
    v_adj_sh_d     = v_adj_sh_q;
    max_scan_sh_d  = max_scan_sh_q;
    row_enter      = 1'b0;

    if (clk_en_i) begin
      if (new_frame) begin
        // row_addr captures start_addr directly; it doubles as its shadow.
        v_total_sh_d   = v_total_i;
        v_disp_sh_d    = v_displayed_i;
        v_adj_sh_d     = v_adjust_i;
        max_scan_sh_d  = max_scan_line_i;
        row_addr_d     = start_addr_i;
        hc_d           = '0;
        ra_d           = '0;
        vc_d           = '0;
        state_d        = ST_ACTIVE;
        frame_start_d  = 1'b1;
        load_pending_d = 1'b0;
        vs_done_d      = 1'b0;
        row_enter      = 1'b1;
        if (!load_pending_q) begin
          frame_count_d = frame_count_q + 5'd1;
        end
      end else begin
        frame_start_d = 1'b0;
        if (state_q == ST_ACTIVE && row_end) begin
          // vc and row_addr still advance when entering ADJUST; ADJUST
          // blanks the display, so only the refresh address is visible.
          hc_d       = '0;
          ra_d       = '0;
          vc_d       = vc_q + V_ONE;
          row_addr_d = row_addr_q + MA_WIDTH'(h_displayed_i);
          row_enter  = 1'b1;
          if (vc_q == v_total_sh_q) begin
            state_d = ST_ADJUST;
          end
        end else if (line_end) begin
          hc_d = '0;
          ra_d = ra_q + RA_ONE;
        end else begin
          hc_d = hc_q + H_ONE;
        end
      end

      // HSYNC may reload only when idle or on its final tick.
      if (hs_cnt_q <= 5'd1 && hc_d == h_sync_pos_i) begin
        hs_cnt_d = hs_len;
      end else if (hs_cnt_q != 5'd0) begin
        hs_cnt_d = hs_cnt_q - 5'd1;
      end

      // VSYNC counts line ends and survives a frame boundary.
      if (row_enter && !vs_done_d && vs_cnt_q <= 5'd1 && vc_d == v_sync_pos_i) begin
        vs_cnt_d  = vs_len;
        vs_done_d = 1'b1;
      end else if (line_end && vs_cnt_q != 5'd0) begin
        vs_cnt_d = vs_cnt_q - 5'd1;
      end
    end
  end

  always_ff @(posedge wb_clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q        <= ST_ACTIVE;
      load_pending_q <= 1'b1;
      hc_q           <= '0;
      ra_q           <= '0;
      vc_q           <= '0;
      row_addr_q     <= '0;
      hs_cnt_q       <= '0;
      vs_cnt_q       <= '0;
      vs_done_q      <= 1'b0;
      frame_start_q  <= 1'b0;
      frame_count_q  <= '0;
      v_total_sh_q   <= '0;
      v_disp_sh_q    <= '0;
      v_adj_sh_q     <= '0;
      max_scan_sh_q  <= '0;
    end else begin
      state_q        <= state_d;
      load_pending_q <= load_pending_d;
      hc_q           <= hc_d;
      ra_q           <= ra_d;
      vc_q           <= vc_d;
      row_addr_q     <= row_addr_d;
      hs_cnt_q       <= hs_cnt_d;
      vs_cnt_q       <= vs_cnt_d;
      vs_done_q      <= vs_done_d;
      frame_start_q  <= frame_start_d;
      frame_count_q  <= frame_count_d;
      v_total_sh_q   <= v_total_sh_d;
      v_disp_sh_q    <= v_disp_sh_d;
      v_adj_sh_q     <= v_adj_sh_d;
      max_scan_sh_q  <= max_scan_sh_d;
    end
  end

  always_comb begin
    case (cursor_mode_i)
      2'b00:   blink_on = 1'b1;
      2'b01:   blink_on = 1'b0;
      2'b10:   blink_on = ~frame_count_q[3];
      default: blink_on = ~frame_count_q[4];
    endcase
  end

  assign de_h          = (hc_q < h_displayed_i);
  assign de_v          = (vc_q < v_disp_sh_q) && (state_q == ST_ACTIVE);
  assign de_o          = de_h && de_v;
  assign ma_o          = row_addr_q + MA_WIDTH'(hc_q);
  assign ra_o          = ra_q;
  assign h_sync_o      = (hs_cnt_q != 5'd0);
  assign v_sync_o      = (vs_cnt_q != 5'd0);
  assign frame_start_o = frame_start_q;
  assign frame_count_o = frame_count_q;
  // An inverted raster range (start > end) can never satisfy both bounds.
  assign cursor_o      = de_o && (ma_o == cursor_addr_i) &&
                         (cursor_start_i <= ra_q) && (ra_q <= cursor_end_i) &&
                         blink_on;

endmodule

// File: tb/tb_video_crtc_gen.sv
// tb_video_crtc_gen -- bench for video_crtc_gen.
// A frame-position model predicts every output from the tick count within
// the current frame and the geometry captured at that frame's start.
module tb_video_crtc_gen;

  logic        wb_clock_i = 1'b0;
  logic        reset_n_i;
  logic        clk_en_i;
  logic [7:0]  h_total_i, h_displayed_i, h_sync_pos_i;
  logic [3:0]  h_sync_width_i, v_sync_width_i;
  logic [6:0]  v_total_i, v_displayed_i, v_sync_pos_i;
  logic [4:0]  v_adjust_i, max_scan_line_i, cursor_start_i, cursor_end_i;
  logic [1:0]  cursor_mode_i;
  logic [13:0] start_addr_i, cursor_addr_i;
  logic        h_sync_o, v_sync_o, de_o, cursor_o, frame_start_o;
  logic [4:0]  frame_count_o;
  logic [13:0] ma_o;
  logic [4:0]  ra_o;

  video_crtc_gen dut (
    .wb_clock_i      (wb_clock_i),
    .reset_n_i       (reset_n_i),
    .clk_en_i        (clk_en_i),
    .h_total_i       (h_total_i),
    .h_displayed_i   (h_displayed_i),
    .h_sync_pos_i    (h_sync_pos_i),
    .h_sync_width_i  (h_sync_width_i),
    .v_sync_width_i  (v_sync_width_i),
    .v_total_i       (v_total_i),
    .v_adjust_i      (v_adjust_i),
    .v_displayed_i   (v_displayed_i),
    .v_sync_pos_i    (v_sync_pos_i),
    .max_scan_line_i (max_scan_line_i),
    .cursor_mode_i   (cursor_mode_i),
    .cursor_start_i  (cursor_start_i),
    .cursor_end_i    (cursor_end_i),
    .start_addr_i    (start_addr_i),
    .cursor_addr_i   (cursor_addr_i),
    .h_sync_o        (h_sync_o),
    .v_sync_o        (v_sync_o),
    .de_o            (de_o),
    .cursor_o        (cursor_o),
    .frame_start_o   (frame_start_o),
    .frame_count_o   (frame_count_o),
    .ma_o            (ma_o),
    .ra_o            (ra_o)
  );

  always #5 wb_clock_i = ~wb_clock_i;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic        cur;
    logic        fs;
    logic [4:0]  fc;
    logic [13:0] ma;
    logic [4:0]  ra;
  } exp_t;

  exp_t expQ[$];
  int   compareCount  = 0;
  int   mismatchCount = 0;

  bit   modelPending;
  int   modelT, modelFc;
  int   snapVTotal, snapVDisp, snapVAdj, snapMaxScan, snapStart;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compareCount++;
    if (obs !== expv) begin
      mismatchCount++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, obs, expv);
    end
  endtask

  task automatic setDefault();
    h_total_i       = 8'd9;
    h_displayed_i   = 8'd6;
    h_sync_pos_i    = 8'd7;
    h_sync_width_i  = 4'd2;
    v_sync_width_i  = 4'd1;
    v_total_i       = 7'd2;
    v_adjust_i      = 5'd0;
    v_displayed_i   = 7'd2;
    v_sync_pos_i    = 7'd1;
    max_scan_line_i = 5'd1;
    cursor_mode_i   = 2'b00;
    cursor_start_i  = 5'd0;
    cursor_end_i    = 5'd1;
    start_addr_i    = 14'h100;
    cursor_addr_i   = 14'h103;
  endtask

  function automatic void snapshot();
    snapVTotal  = int'(v_total_i);
    snapVDisp   = int'(v_displayed_i);
    snapVAdj    = int'(v_adjust_i);
    snapMaxScan = int'(max_scan_line_i);
    snapStart   = int'(start_addr_i);
  endfunction

  function automatic void modelReset();
    modelPending = 1'b1;
    modelT       = 0;
    modelFc      = 0;
    snapVTotal   = 0;
    snapVDisp    = 0;
    snapVAdj     = 0;
    snapMaxScan  = 0;
    snapStart    = 0;
  endfunction

  function automatic void modelTick();
    int frameLen;
    if (modelPending) begin
      modelPending = 1'b0;
      modelT       = 0;
      snapshot();
    end else begin
      frameLen = ((snapVTotal + 1) * (snapMaxScan + 1) + snapVAdj) * (int'(h_total_i) + 1);
      modelT++;
      if (modelT == frameLen) begin
        modelT  = 0;
        modelFc = (modelFc + 1) % 32;
        snapshot();
      end
    end
  endfunction

  function automatic exp_t modelOutputs();
    exp_t e;
    int   lineLen, linesPerRow, activeLines, line, hc, row, ra, ma, n, m, vsStart;
    bit   adj, blink;
    e = '0;
    if (modelPending) return e;
    lineLen     = int'(h_total_i) + 1;
    linesPerRow = snapMaxScan + 1;
    activeLines = (snapVTotal + 1) * linesPerRow;
    line        = modelT / lineLen;
    hc          = modelT % lineLen;
    adj         = 1'b0;
    if (line < activeLines) begin
      row = line / linesPerRow;
      ra  = line % linesPerRow;
    end else begin
      adj = 1'b1;
      row = snapVTotal + 1;
      ra  = line - activeLines;
    end
    ma   = (snapStart + row * int'(h_displayed_i) + hc) % 16384;
    e.ma = 14'(ma);
    e.ra = 5'(ra);
    e.de = (hc < int'(h_displayed_i)) && (row < snapVDisp) && !adj;
    n    = (h_sync_width_i == 4'd0) ? 16 : int'(h_sync_width_i);
    e.hs = (((hc - int'(h_sync_pos_i) + lineLen) % lineLen) < n);
    m       = (v_sync_width_i == 4'd0) ? 16 : int'(v_sync_width_i);
    vsStart = int'(v_sync_pos_i) * linesPerRow;
    e.vs = (line >= vsStart) && (line < vsStart + m);
    case (cursor_mode_i)
      2'b00:   blink = 1'b1;
      2'b01:   blink = 1'b0;
      2'b10:   blink = ((modelFc & 8) == 0);
      default: blink = ((modelFc & 16) == 0);
    endcase
    e.cur = e.de && (ma == int'(cursor_addr_i)) && (int'(cursor_start_i) <= ra) &&
            (ra <= int'(cursor_end_i)) && blink;
    e.fs  = (modelT == 0);
    e.fc  = 5'(modelFc);
    return e;
  endfunction

  task automatic applyStimulus(input bit en);
    clk_en_i = en;
    if (en) modelTick();
    expQ.push_back(modelOutputs());
  endtask

  task automatic compareNext();
    exp_t e;
    e = expQ.pop_front();
    checkOutput("h_sync",      32'(h_sync_o),      32'(e.hs));
    checkOutput("v_sync",      32'(v_sync_o),      32'(e.vs));
    checkOutput("de",          32'(de_o),          32'(e.de));
    checkOutput("cursor",      32'(cursor_o),      32'(e.cur));
    checkOutput("frame_start", 32'(frame_start_o), 32'(e.fs));
    checkOutput("frame_count", 32'(frame_count_o), 32'(e.fc));
    checkOutput("ma",          32'(ma_o),          32'(e.ma));
    checkOutput("ra",          32'(ra_o),          32'(e.ra));
  endtask

  task automatic stepOnce(input bit en);
    @(negedge wb_clock_i);
    applyStimulus(en);
    @(posedge wb_clock_i);
    #1;
    compareNext();
  endtask

  // Advances n enabled ticks with random idle cycles mixed in.
  task automatic runTicks(input int n);
    int done;
    bit en;
    done = 0;
    while (done < n) begin
      en = ($urandom_range(0, 3) != 0);
      stepOnce(en);
      if (en) done++;
    end
  endtask

  task automatic doReset();
    @(negedge wb_clock_i);
    clk_en_i  = 1'b0;
    reset_n_i = 1'b0;
    modelReset();
    #1;
    expQ.push_back(modelOutputs());
    compareNext();
    stepOnce(1'b0);
    @(negedge wb_clock_i);
    reset_n_i = 1'b1;
  endtask

  // Reset lands between clock edges while clk_en is low; outputs must clear
  // without waiting for a clock.
  task automatic midLineReset();
    clk_en_i = 1'b0;
    #2;
    reset_n_i = 1'b0;
    modelReset();
    #1;
    expQ.push_back(modelOutputs());
    compareNext();
    stepOnce(1'b0);
    stepOnce(1'b0);
    @(negedge wb_clock_i);
    reset_n_i = 1'b1;
    stepOnce(1'b1);
  endtask

  initial begin
    reset_n_i = 1'b0;
    clk_en_i  = 1'b0;
    setDefault();
    modelReset();

    // Base geometry: 60-tick frames, then a mid-line reset.
    doReset();
    runTicks(185);
    midLineReset();
    runTicks(65);

    // 16-character HSYNC on a 40-character line.
    setDefault();
    h_total_i      = 8'd39;
    h_sync_width_i = 4'd0;
    doReset();
    runTicks(500);

    // Three vertical-adjust lines: 90-tick frames.
    setDefault();
    v_adjust_i = 5'd3;
    doReset();
    runTicks(280);

    // v_total rewritten mid-frame takes effect on the following frame.
    setDefault();
    doReset();
    runTicks(30);
    v_total_i = 7'd4;
    runTicks(270);

    // Cursor blink every 8 frames, then off, then blink every 16 frames
    // across the frame counter wrap.
    setDefault();
    cursor_end_i  = 5'd0;
    cursor_mode_i = 2'b10;
    doReset();
    runTicks(17 * 60 + 5);
    cursor_mode_i = 2'b01;
    runTicks(120);
    cursor_mode_i = 2'b11;
    doReset();
    runTicks(34 * 60 + 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/video_crtc_gen.md
Name: video_crtc_gen

Overview:
- Parametrised successor to the PET 6845-style CRTC timing core.
- Generates h/v sync, display enable, refresh address (MA) and raster address (RA) from register values supplied by the CRTC register block.
- Adds hardware cursor with blink modes, a frame counter, and frame-boundary shadowing of vertical and address geometry.
- Sits between the CRTC register file and the video pixel/character fetch pipeline.

Parameters:
- H_WIDTH, 8, width of horizontal character counters (R0/R1/R2).
- V_WIDTH, 7, width of vertical row counters (R4/R6/R7).
- RA_WIDTH, 5, width of raster counter (R9/R5/R10/R11).
- MA_WIDTH, 14, width of refresh address (R12/13, R14/15).

Ports:
- wb_clock_i  in  1  system clock
- reset_n_i  in  1  asynchronous, active-low reset
- clk_en_i  in  1  character-clock enable; all state advances only when high
- h_total_i  in  H_WIDTH  R0: last column index (line length = h_total_i+1)
- h_displayed_i  in  H_WIDTH  R1: displayed columns
- h_sync_pos_i  in  H_WIDTH  R2: column where HSYNC starts
- h_sync_width_i  in  4  R3[3:0]: HSYNC width in chars; 0 means 16
- v_sync_width_i  in  4  R3[7:4]: VSYNC width in lines; 0 means 16
- v_total_i  in  V_WIDTH  R4: last row index
- v_adjust_i  in  RA_WIDTH  R5: extra scan lines after last row
- v_displayed_i  in  V_WIDTH  R6: displayed rows
- v_sync_pos_i  in  V_WIDTH  R7: row where VSYNC starts
- max_scan_line_i  in  RA_WIDTH  R9: last raster line of a row
- cursor_mode_i  in  2  R10[6:5]: 00 steady, 01 off, 10 blink/16, 11 blink/32
- cursor_start_i  in  RA_WIDTH  R10: first cursor raster line
- cursor_end_i  in  RA_WIDTH  R11: last cursor raster line
- start_addr_i  in  MA_WIDTH  R12/13: frame start address
- cursor_addr_i  in  MA_WIDTH  R14/15: cursor address
- h_sync_o  out  1  horizontal sync
- v_sync_o  out  1  vertical sync
- de_o  out  1  display enable
- cursor_o  out  1  cursor active at current MA/RA
- frame_start_o  out  1  one-clk_en pulse on the first character of each frame
- frame_count_o  out  5  frame counter; wraps 31→0
- ma_o  out  MA_WIDTH  refresh address
- ra_o  out  RA_WIDTH  raster address

Behaviour:
- Reset (async on reset_n_i low): all counters, shadows and outputs are 0. A load_pending flag is set.
- While clk_en_i is low, no state changes and outputs hold.
- First clk_en_i after reset:
  - Loads the shadows: v_total, v_displayed, v_adjust, max_scan_line, start_addr.
  - Clears counters and pulses frame_start_o.
- Horizontal:
  - hc counts 0..h_total_i; line_end = (hc == h_total_i); hc returns to 0 after line_end.
  - de_h = (hc < h_displayed_i). Horizontal registers are live (not shadowed).
- HSYNC:
  - Asserted starting at the clk_en tick where hc == h_sync_pos_i.
  - Lasts exactly N ticks, where N = h_sync_width_i, or 16 if 0.
  - If the start condition recurs while active, it does not retrigger.
- Raster:
  - ra counts 0..shadow max_scan_line, incrementing at line_end.
  - row_end = line_end && ra == max_scan_line.
- Vertical:
  - vc increments at row_end.
  - After row_end with vc == v_total: if v_adjust == 0, frame ends; otherwise enter the ADJUST state.
  - ADJUST runs v_adjust further lines (ra counts 0..v_adjust-1), then the frame ends.
  - States: ACTIVE → ADJUST → ACTIVE.
- Frame end (next tick):
  - vc = 0, ra = 0, hc = 0.
  - Shadows reload from the inputs; frame_start_o = 1.
  - frame_count_o increments.
- de_v = (vc < v_displayed) and not ADJUST. de_o = de_h && de_v.
- VSYNC:
  - Asserted at the first line of row vc == v_sync_pos_i (tick after the row_end that enters it).
  - Lasts M line_ends, where M = v_sync_width_i, or 16 if 0. At most one VSYNC per frame.
  - An in-progress VSYNC continues across a frame end.
- Address:
  - row_addr loads shadow start_addr at frame start.
  - At row_end (not in ADJUST), row_addr += h_displayed_i, modulo 2^MA_WIDTH.
  - ma_o = row_addr + hc, truncated to MA_WIDTH.
- Cursor:
  - cursor_o = de_o && ma_o == cursor_addr_i && cursor_start_i ≤ ra_o ≤ cursor_end_i && blink_on.
  - blink_on per cursor_mode_i:
    - 00: 1
    - 01: 0
    - 10: frame_count_o[3] == 0
    - 11: frame_count_o[4] == 0
  - cursor_start_i > cursor_end_i means no cursor.
- Geometry registers written mid-frame affect vertical/address timing only from the next frame. h_total_i < hc mid-line lets hc wrap through 2^H_WIDTH (same as 6845).

Test Plan:
- Geometry h_total=9, h_disp=6, max_scan=1, v_total=2, v_disp=2, v_adjust=0, start=0x100 → frame = 60 ticks; ma sequence 0x100..0x105, then 0x106 on row 1; de high for 6 of every 10 ticks on rows 0-1; frame_start_o every 60 ticks.
- h_sync_pos=7, h_sync_width=0, h_total=39 → h_sync_o high for exactly 16 ticks starting at hc=7.
- v_adjust=3 with the geometry above → frame = 90 ticks; de_o low and ma not advanced during the 3 adjust lines; frame_count_o increments once.
- Change v_total from 2 to 4 mid-frame → current frame keeps 60 ticks; next frame is 100 ticks.
- cursor_addr=0x103, start=0, end=0, mode=10 → cursor_o single tick on ra=0 in frames 0-7, absent in frames 8-15; with mode=01, never asserted.
- Pulse reset_n_i low mid-line, with clk_en_i held low → all outputs 0 immediately; first clk_en_i after release gives frame_start_o=1, ma_o=start_addr.
